bitstream_word_packer: RTL and testbench

//  Downstream of the bit packer. Consumes its per-cycle byte output
//  (0..4 MSB-first bytes in a 32-bit word) and repacks it into aligned
//  32-bit words. Buffers the words in a FIFO and writes them to the

---
 rtl/bitstream_word_packer_if.sv | 33 +++
 rtl/bitstream_word_packer.sv | 157 +++++++++++++++
 tb/tb_bitstream_word_packer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/bitstream_word_packer_if.sv
// Stream-input and memory-write bundle for bitstream_word_packer.
// slave = packer side, master = producer/memory side.
interface bitstream_word_packer_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [3:0]        in_byte_count;
  logic [31:0]       in_data;
  logic              flush;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              mem_ready;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wr_data;
  logic [3:0]        mem_byte_en;
  logic              busy;
  logic              done;
  logic              overflow;
  logic              bad_count;
  logic [31:0]       byte_total;

  modport slave (
    input  in_byte_count, in_data, flush, start, start_addr, mem_ready,
    output mem_wr_en, mem_addr, mem_wr_data, mem_byte_en,
           busy, done, overflow, bad_count, byte_total
  );

  modport master (
    output in_byte_count, in_data, flush, start, start_addr, mem_ready,
    input  mem_wr_en, mem_addr, mem_wr_data, mem_byte_en,
           busy, done, overflow, bad_count, byte_total
  );
endinterface

// File: rtl/bitstream_word_packer.sv
// Repacks 0..4 MSB-first bytes per cycle into aligned 32-bit words, buffers them
// in a FIFO and writes them out under backpressure. Option: BITSTREAM_WORD_PACKER_LE_EN.
module bitstream_word_packer #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  bitstream_word_packer_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_RUN, S_PAD, S_DRAIN, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [23:0]       r_stage, w_stage_nxt;
  logic [1:0]        r_stage_cnt, w_stage_cnt_nxt;
  logic [35:0]       r_fifo [FIFO_DEPTH];
  logic [PTR_W:0]    r_wptr, r_rptr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_overflow, r_bad;
  logic [31:0]       r_total;

  logic [3:0]        w_n;
  logic              w_take, w_bad;
  logic [31:0]       w_mask;
  logic [55:0]       w_cat;
  logic [2:0]        w_sum;
  logic              w_push, w_pop, w_wr, w_drop;
  logic [35:0]       w_push_word, w_head;
  logic [PTR_W:0]    w_count;
  logic              w_empty, w_full;

  assign w_n     = bus.in_byte_count;
  assign w_take  = (r_state == S_RUN) && (w_n != 4'd0) && (w_n <= 4'd4);
  assign w_bad   = (r_state == S_RUN) && (w_n > 4'd4);
  assign w_count = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (w_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_pop   = !w_empty && bus.mem_ready;
  // A full FIFO still accepts when it is popped the same cycle.
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;
  assign w_sum   = {1'b0, r_stage_cnt} + w_n[2:0];

  always_comb begin
    w_mask = '0;
    case (w_n)
      4'd1:    w_mask = 32'hFF00_0000;
      4'd2:    w_mask = 32'hFFFF_0000;
      4'd3:    w_mask = 32'hFFFF_FF00;
      4'd4:    w_mask = 32'hFFFF_FFFF;
      default: w_mask = '0;
    endcase
  end

  // Staged bytes sit at the top; the new bytes land right after them.
  assign w_cat = {r_stage, 32'h0} | ({bus.in_data & w_mask, 24'h0} >> {r_stage_cnt, 3'b000});

  always_comb begin
    w_state_nxt     = r_state;
    w_stage_nxt     = r_stage;
    w_stage_cnt_nxt = r_stage_cnt;
    w_push          = 1'b0;
    w_push_word     = '0;
    case (r_state)
      S_RUN: begin
        if (w_take) begin
          if (w_sum >= 3'd4) begin
            w_push          = 1'b1;
            w_push_word     = {w_cat[55:24], 4'b1111};
            w_stage_nxt     = w_cat[23:0];
            w_stage_cnt_nxt = 2'(w_sum - 3'd4);
          end else begin
            w_stage_nxt     = w_cat[55:32];
            w_stage_cnt_nxt = w_sum[1:0];
          end
        end
        if (bus.flush) w_state_nxt = S_PAD;
      end
      S_PAD: begin
        if (r_stage_cnt != 2'd0) begin
          w_push = 1'b1;
          case (r_stage_cnt)
            2'd1:    w_push_word = {r_stage, 8'h00, 4'b1000};
            2'd2:    w_push_word = {r_stage, 8'h00, 4'b1100};
            default: w_push_word = {r_stage, 8'h00, 4'b1110};
          endcase
        end
        w_stage_nxt     = '0;
        w_stage_cnt_nxt = '0;
        w_state_nxt     = S_DRAIN;
      end
      S_DRAIN: begin
        // Leave as the last entry pops so done follows the final write directly.
        if (w_empty || (w_count == (PTR_W+1)'(1) && w_pop)) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_stage     <= '0;
      r_stage_cnt <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_addr      <= '0;
      r_overflow  <= 1'b0;
      r_bad       <= 1'b0;
      r_total     <= '0;
    end else if (bus.start) begin
      r_state     <= S_RUN;
      r_stage     <= '0;
      r_stage_cnt <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_addr      <= bus.start_addr;
      r_overflow  <= 1'b0;
      r_bad       <= 1'b0;
      r_total     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_stage     <= w_stage_nxt;
      r_stage_cnt <= w_stage_cnt_nxt;
      if (w_wr)   r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_addr <= r_addr + 1'b1;
      end
      if (w_drop) r_overflow <= 1'b1;
      if (w_bad)  r_bad <= 1'b1;
      if (w_take) r_total <= r_total + {28'h0, w_n};
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr) r_fifo[r_wptr[PTR_W-1:0]] <= w_push_word;
  end

  assign w_head        = r_fifo[r_rptr[PTR_W-1:0]];
  assign bus.mem_wr_en = !w_empty;
  assign bus.mem_addr  = r_addr;
`ifdef BITSTREAM_WORD_PACKER_LE_EN
  assign bus.mem_wr_data = {w_head[11:4], w_head[19:12], w_head[27:20], w_head[35:28]};
  assign bus.mem_byte_en = {w_head[0], w_head[1], w_head[2], w_head[3]};
`else
  assign bus.mem_wr_data = w_head[35:4];
  assign bus.mem_byte_en = w_head[3:0];
`endif
  assign bus.busy       = (r_state != S_RUN);
  assign bus.done       = (r_state == S_DONE);
  assign bus.overflow   = r_overflow;
  assign bus.bad_count  = r_bad;
  assign bus.byte_total = r_total;
endmodule

// File: tb/tb_bitstream_word_packer.sv
// Directed bench for bitstream_word_packer: packing, flush/pad, backpressure
// with overflow, bad counts, start mid-drain, and output byte order.
module tb_bitstream_word_packer;
  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  bitstream_word_packer_if #(.ADDR_W(16)) bus ();

  bitstream_word_packer #(.ADDR_W(16), .FIFO_DEPTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  function automatic logic [31:0] ed(input logic [31:0] d);
`ifdef BITSTREAM_WORD_PACKER_LE_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  function automatic logic [3:0] eb(input logic [3:0] b);
`ifdef BITSTREAM_WORD_PACKER_LE_EN
    return {b[0], b[1], b[2], b[3]};
`else
    return b;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] n, input logic [31:0] d, input logic fl);
    bus.in_byte_count = n;
    bus.in_data       = d;
    bus.flush         = fl;
  endtask

  logic [31:0] w;

  initial begin
    reset = 1'b1;
    drive(4'd0, 32'h0, 1'b0);
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.mem_ready = 1'b0;
    step(); step();
    chk("rst_wr_en", bus.mem_wr_en, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_bad", bus.bad_count, 0);
    chk("rst_total", bus.byte_total, 0);
    reset = 1'b0;

    // T1: 3,3,2 bytes
    bus.mem_ready = 1'b1;
    drive(4'd3, 32'hAABBCC00, 1'b0); step();
    chk("t1_nowr", bus.mem_wr_en, 0);
    chk("t1_total3", bus.byte_total, 3);
    drive(4'd3, 32'hDDEEFF00, 1'b0); step();
    chk("t1_wr0", bus.mem_wr_en, 1);
    chk("t1_d0", bus.mem_wr_data, ed(32'hAABBCCDD));
    chk("t1_be0", bus.mem_byte_en, eb(4'b1111));
    chk("t1_a0", bus.mem_addr, 0);
    drive(4'd2, 32'h11220000, 1'b0); step();
    chk("t1_wr1", bus.mem_wr_en, 1);
    chk("t1_d1", bus.mem_wr_data, ed(32'hEEFF1122));
    chk("t1_a1", bus.mem_addr, 1);
    drive(4'd0, 32'h0, 1'b0); step();
    chk("t1_idle", bus.mem_wr_en, 0);
    chk("t1_a2", bus.mem_addr, 2);
    chk("t1_total", bus.byte_total, 8);

    // T2: single byte plus flush
    drive(4'd1, 32'h5A000000, 1'b1); step();
    chk("t2_busy_pad", bus.busy, 1);
    chk("t2_nowr", bus.mem_wr_en, 0);
    drive(4'd0, 32'h0, 1'b0); step();
    chk("t2_wr", bus.mem_wr_en, 1);
    chk("t2_d", bus.mem_wr_data, ed(32'h5A000000));
    chk("t2_be", bus.mem_byte_en, eb(4'b1000));
    chk("t2_a", bus.mem_addr, 2);
    chk("t2_busy_drain", bus.busy, 1);
    chk("t2_nodone", bus.done, 0);
    step();
    chk("t2_done", bus.done, 1);
    chk("t2_busy_done", bus.busy, 1);
    chk("t2_a3", bus.mem_addr, 3);
    chk("t2_empty", bus.mem_wr_en, 0);
    step();
    chk("t2_done_off", bus.done, 0);
    chk("t2_busy_off", bus.busy, 0);
    chk("t2_total", bus.byte_total, 9);

    // T4: illegal count
    drive(4'd7, 32'hFFFFFFFF, 1'b0); step();
    chk("t4_bad", bus.bad_count, 1);
    chk("t4_total", bus.byte_total, 9);
    drive(4'd0, 32'h0, 1'b0); step();
    chk("t4_nowr", bus.mem_wr_en, 0);

    // T3: backpressure, FIFO_DEPTH+1 words
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      w = 32'h10203040 + 32'h01010101 * 32'(i);
      drive(4'd4, w, 1'b0); step();
      if (i == 7) chk("t3_no_ovf", bus.overflow, 0);
    end
    chk("t3_ovf", bus.overflow, 1);
    drive(4'd0, 32'h0, 1'b0); step();
    chk("t3_wr_hold", bus.mem_wr_en, 1);
    chk("t3_d_hold", bus.mem_wr_data, ed(32'h10203040));
    chk("t3_a_hold", bus.mem_addr, 3);
    chk("t3_total", bus.byte_total, 45);
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w = 32'h10203040 + 32'h01010101 * 32'(i);
      chk("t3_wr", bus.mem_wr_en, 1);
      chk("t3_d", bus.mem_wr_data, ed(w));
      chk("t3_a", bus.mem_addr, 64'(3 + i));
      step();
    end
    chk("t3_drained", bus.mem_wr_en, 0);
    chk("t3_a_end", bus.mem_addr, 11);

    // T5: start during DRAIN
    bus.mem_ready = 1'b0;
    drive(4'd4, 32'hCAFEF00D, 1'b1); step();
    drive(4'd0, 32'h0, 1'b0); step(); step();
    chk("t5_busy", bus.busy, 1);
    chk("t5_wr_pending", bus.mem_wr_en, 1);
    bus.start = 1'b1;
    bus.start_addr = 16'h0100;
    step();
    bus.start = 1'b0;
    chk("t5_wr_cleared", bus.mem_wr_en, 0);
    chk("t5_addr", bus.mem_addr, 16'h0100);
    chk("t5_busy_off", bus.busy, 0);
    chk("t5_ovf_clr", bus.overflow, 0);
    chk("t5_bad_clr", bus.bad_count, 0);
    chk("t5_total_clr", bus.byte_total, 0);
    step();
    chk("t5_nodone", bus.done, 0);
    bus.mem_ready = 1'b1;
    drive(4'd4, 32'h01234567, 1'b0); step();
    chk("t5_d", bus.mem_wr_data, ed(32'h01234567));
    chk("t5_a", bus.mem_addr, 16'h0100);
    drive(4'd0, 32'h0, 1'b0); step();
    chk("t5_a_next", bus.mem_addr, 16'h0101);

    // T6: byte order, single-byte steps then partial flush
    drive(4'd1, 32'h01000000, 1'b0); step();
    drive(4'd1, 32'h02000000, 1'b0); step();
    drive(4'd1, 32'h03000000, 1'b0); step();
    drive(4'd1, 32'h04000000, 1'b0); step();
    chk("t6_wr0", bus.mem_wr_en, 1);
    chk("t6_d0", bus.mem_wr_data, ed(32'h01020304));
    chk("t6_be0", bus.mem_byte_en, eb(4'b1111));
    chk("t6_a0", bus.mem_addr, 16'h0101);
    drive(4'd1, 32'h05000000, 1'b1); step();
    chk("t6_nowr", bus.mem_wr_en, 0);
    chk("t6_busy", bus.busy, 1);
    drive(4'd0, 32'h0, 1'b0); step();
    chk("t6_d1", bus.mem_wr_data, ed(32'h05000000));
    chk("t6_be1", bus.mem_byte_en, eb(4'b1000));
    chk("t6_a1", bus.mem_addr, 16'h0102);
    step();
    chk("t6_done", bus.done, 1);
    chk("t6_a2", bus.mem_addr, 16'h0103);
    step();
    chk("t6_done_off", bus.done, 0);
    chk("t6_total", bus.byte_total, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
